// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the display scheduler: display phase codes (common with the
// display controller) and the scheduler FSM encoding.
package display_scheduler_pkg;

  localparam logic [1:0] PHASE_HUNDREDS = 2'd0;
  localparam logic [1:0] PHASE_TENS     = 2'd1;
  localparam logic [1:0] PHASE_ONES     = 2'd2;
  localparam logic [1:0] PHASE_BLANK    = 2'd3;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StShow,
    StGap
  } state_e;

  // Number of controller steps needed to walk from hundreds to blank after reset.
  localparam int unsigned InitSteps = 3;

  function automatic logic [1:0] phase_step(input logic [1:0] phase, input logic step);
    return phase + {1'b0, step};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: favours whichever requester did not win last time.
module rr_arbiter2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = req_a | req_b;
    if (last_owner) begin
      grant_sel = req_a ? 1'b0 : 1'b1;
    end else begin
      grant_sel = req_b ? 1'b1 : 1'b0;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates two requesters onto one 3-digit display, holding the granted number stable
// and pacing hundreds/tens/ones steps with a dwell timer, then a blank gap.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned CNT_W        = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] value_a,
  input  logic       req_b,
  input  logic [7:0] value_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       trigger,
  output logic [7:0] value,
  output logic       busy,
  output logic       owner
);

  localparam logic [CNT_W-1:0] DwellLast  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] InitLast   = CNT_W'(InitSteps);
  localparam int unsigned      GapLastInt = (GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] GapLast    = CNT_W'(GapLastInt);
  // The blank cycle that carries the final trigger already counts toward the gap.
  localparam bit               GapSkip    = (GAP_CYCLES < 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       phase_q, phase_d;
  logic             owner_q, owner_d;
  logic [7:0]       value_q, value_d;

  logic grant_valid;
  logic grant_sel;
  logic dwell_done;
  logic number_done;

  rr_arbiter2 u_arbiter (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  assign dwell_done  = (state_q == StShow) && (timer_q == DwellLast);
  assign number_done = dwell_done && (phase_q == PHASE_ONES);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      timer_q <= '0;
      phase_q <= PHASE_HUNDREDS;
      owner_q <= 1'b1;
      value_q <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      owner_q <= owner_d;
      value_q <= value_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    owner_d = owner_q;
    value_d = value_q;
    unique case (state_q)
      StInit: begin
        if (timer_q == InitLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StIdle: begin
        if (grant_valid) begin
          state_d = StShow;
          timer_d = '0;
          owner_d = grant_sel;
          value_d = grant_sel ? value_b : value_a;
        end
      end
      StShow: begin
        if (dwell_done) begin
          timer_d = '0;
          if (number_done) begin
            state_d = GapSkip ? StIdle : StGap;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StInit;
        timer_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    trigger = 1'b0;
    ack_a   = 1'b0;
    ack_b   = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      StInit: begin
        // Cycle 0 after release is quiet; steps follow on cycles 1..3.
        trigger = (timer_q != '0);
      end
      StIdle: begin
        busy    = 1'b0;
        trigger = grant_valid;
      end
      StShow: begin
        trigger = dwell_done;
        ack_a   = number_done & ~owner_q;
        ack_b   = number_done & owner_q;
      end
      StGap: begin
        trigger = 1'b0;
      end
      default: begin
        trigger = 1'b0;
      end
    endcase
  end

  assign phase_d = phase_step(phase_q, trigger);
  assign value   = value_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with DWELL_CYCLES=4, GAP_CYCLES=2.
module tb_display_scheduler;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic [7:0] value_a;
  logic       req_b;
  logic [7:0] value_b;
  logic       ack_a;
  logic       ack_b;
  logic       trigger;
  logic [7:0] value;
  logic       busy;
  logic       owner;

  int tests;
  int fails;

  logic [63:0] trig_v;
  logic [63:0] acka_v;
  logic [63:0] ackb_v;
  logic [63:0] busy_v;
  logic [7:0]  vals [64];

  display_scheduler #(
    .DWELL_CYCLES (4),
    .GAP_CYCLES   (2),
    .CNT_W        (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .value_a (value_a),
    .req_b   (req_b),
    .value_b (value_b),
    .ack_a   (ack_a),
    .ack_b   (ack_b),
    .trigger (trigger),
    .value   (value),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bit_at(input int p);
    return 64'(1) << p;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Triggers of one number granted at cycle s: grant, then every 4 cycles.
  function automatic logic [63:0] number_trigs(input int s);
    return bit_at(s) | bit_at(s + 4) | bit_at(s + 8) | bit_at(s + 12);
  endfunction

  // Caller is already inside cycle 0 with inputs set; samples n cycles.
  task automatic run_window(input int n, input int drop_a_at, input int drop_b_at,
                            input int rst_at);
    trig_v = '0;
    acka_v = '0;
    ackb_v = '0;
    busy_v = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == drop_a_at) req_a = 1'b0;
      if (i == drop_b_at) req_b = 1'b0;
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
      #1;
      trig_v[i] = trigger;
      acka_v[i] = ack_a;
      ackb_v[i] = ack_b;
      busy_v[i] = busy;
      vals[i]   = value;
    end
  endtask

  initial begin
    logic [7:0] vor;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    value_a = 8'd0;
    value_b = 8'd0;

    // 1: reset values, then INIT stepping
    cyc();
    #1;
    chk("rst_trigger", 64'(trigger), 64'(0));
    chk("rst_value", 64'(value), 64'(0));
    chk("rst_acks", 64'({ack_a, ack_b}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_owner", 64'(owner), 64'(1));
    cyc();
    rst = 1'b0;
    run_window(8, -1, -1, -1);
    chk("init_trig", trig_v, bit_at(1) | bit_at(2) | bit_at(3));
    chk("init_busy", busy_v, span(0, 3));
    chk("init_acks", acka_v | ackb_v, 64'(0));
    vor = '0;
    for (int i = 0; i < 8; i++) vor |= vals[i];
    chk("init_value", 64'(vor), 64'(0));

    // 2: single request from A
    cyc();
    req_a   = 1'b1;
    value_a = 8'd123;
    run_window(16, 1, -1, -1);
    chk("a_trig", trig_v, number_trigs(0));
    chk("a_ack_a", acka_v, bit_at(12));
    chk("a_ack_b", ackb_v, 64'(0));
    chk("a_busy", busy_v, span(1, 13));
    chk("a_value", 64'({vals[1], vals[13]}), 64'({8'd123, 8'd123}));

    // 3: tie on first grant after reset goes to A, then B
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    req_a   = 1'b1;
    req_b   = 1'b1;
    value_a = 8'd45;
    value_b = 8'd200;
    run_window(30, 1, 15, -1);
    chk("tie_trig", trig_v, number_trigs(0) | number_trigs(14));
    chk("tie_ack_a", acka_v, bit_at(12));
    chk("tie_ack_b", ackb_v, bit_at(26));
    chk("tie_value", 64'({vals[1], vals[14], vals[15], vals[29]}),
        64'({8'd45, 8'd45, 8'd200, 8'd200}));
    chk("tie_owner", 64'(owner), 64'(1));

    // 4: both held continuously, four numbers alternate
    cyc();
    req_a   = 1'b1;
    req_b   = 1'b1;
    value_a = 8'd11;
    value_b = 8'd22;
    run_window(56, 55, 55, -1);
    chk("rr_trig", trig_v, number_trigs(0) | number_trigs(14) | number_trigs(28) |
        number_trigs(42));
    chk("rr_ack_a", acka_v, bit_at(12) | bit_at(40));
    chk("rr_ack_b", ackb_v, bit_at(26) | bit_at(54));
    chk("rr_value", 64'({vals[1], vals[15], vals[29], vals[43]}),
        64'({8'd11, 8'd22, 8'd11, 8'd22}));

    // 5: reset in the middle of a SHOW
    cyc();
    req_a   = 1'b1;
    value_a = 8'd99;
    run_window(14, 1, -1, 6);
    chk("mid_rst_trig", trig_v, bit_at(0) | bit_at(4) | bit_at(9) | bit_at(10) | bit_at(11));
    chk("mid_rst_acks", acka_v | ackb_v, 64'(0));
    chk("mid_rst_value", 64'({vals[6], vals[7], vals[13]}), 64'({8'd99, 8'd0, 8'd0}));
    chk("mid_rst_busy", busy_v, span(1, 11));
    chk("mid_rst_owner", 64'(owner), 64'(1));

    // 6: B drops its request mid-number; the number still completes
    cyc();
    req_b   = 1'b1;
    value_b = 8'd7;
    run_window(16, -1, 5, -1);
    chk("drop_trig", trig_v, number_trigs(0));
    chk("drop_ack_b", ackb_v, bit_at(12));
    chk("drop_ack_a", acka_v, 64'(0));
    chk("drop_value", 64'(vals[1]), 64'(8'd7));
    chk("drop_busy", busy_v, span(1, 13));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
